param_fifo: RTL and testbench

Parametrised synchronous FIFO: the successor to the fixed 8-bit, 4-entry byte FIFO used in the SoC peripherals (UART, SPI). It adds configurable data width and depth, non-power-of-two depth support, a fill-level output, programmable almost-full and almost-empty flags, a synchronous flush, and optional sticky overflow/underflow error flags. It sits between a peripheral's bus-side register interface and its serial engine, in the same position as the byte FIFO it replaces.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_mem.sv | 23 ++
 rtl/param_fifo.sv | 110 +++++++++++
 tb/tb_param_fifo.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers and types for the parametrised FIFO: level width, pointer wrap, status bundle.
package fifo_pkg;

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit compare keeps non-power-of-two depths wrapping correctly.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous show-ahead FIFO with level counter and programmable almost flags.
// Optional sticky overflow/underflow registers are built when PARAM_FIFO_ERR_EN is defined.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int LW      = level_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [LW-1:0]    level,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [WIDTH-1:0] mem_rdata;
  logic             push_ok;
  logic             pop_ok;
  fifo_status_t     status;

  assign status.full         = (level == LW'(DEPTH));
  assign status.empty        = (level == '0);
  assign status.almost_full  = (level >= LW'(AF_LEVEL));
  assign status.almost_empty = (level <= LW'(AE_LEVEL));

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;

  // A push into a full FIFO is still accepted when a pop frees the head slot in the same cycle.
  assign push_ok = push && (!status.full || pop);
  assign pop_ok  = pop && !status.empty;

  fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .PW   (PW)
  ) u_mem (
    .clk  (clk),
    .we   (push_ok && !flush),
    .waddr(wptr),
    .wdata(wdata),
    .raddr(rptr),
    .rdata(mem_rdata)
  );

  assign rdata = status.empty ? '0 : mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= PW'(ptr_next(32'(wptr), DEPTH));
      if (pop_ok)  rptr <= PW'(ptr_next(32'(rptr), DEPTH));
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef PARAM_FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (flush) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push && status.full && !pop) overflow_q  <= 1'b1;
      if (pop && status.empty)         underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Directed self-checking bench for param_fifo at WIDTH=8, DEPTH=5, AF_LEVEL=4, AE_LEVEL=1.
module tb_param_fifo;

`ifdef PARAM_FIFO_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       push;
  logic [7:0] wdata;
  logic       pop;
  logic [7:0] rdata;
  logic       flush;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] level;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  param_fifo #(
    .WIDTH   (8),
    .DEPTH   (5),
    .AF_LEVEL(4),
    .AE_LEVEL(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .wdata       (wdata),
    .pop         (pop),
    .rdata       (rdata),
    .flush       (flush),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic p, input logic [7:0] d, input logic q, input logic f);
    push  = p;
    wdata = d;
    pop   = q;
    flush = f;
    tick();
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
    wdata = 8'h00;
  endtask

  task automatic test_reset();
    checks++;
    if ({full, empty, almost_full, almost_empty, overflow, underflow} !== 6'b010100) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b want 010100",
               {full, empty, almost_full, almost_empty, overflow, underflow});
    end
    checks++;
    if (level !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_level got %0d want 0", level);
    end
    checks++;
    if (rdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_rdata got %h want 00", rdata);
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] d;
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i * 8'h11);
      cycle(1'b1, d, 1'b0, 1'b0);
      checks++;
      if (level !== 3'(i)) begin
        errors++;
        $display("[TB] FAIL fill_level got %0d want %0d", level, i);
      end
      checks++;
      if (almost_full !== (i >= 4)) begin
        errors++;
        $display("[TB] FAIL fill_almost_full got %b want %b at level %0d", almost_full, (i >= 4), i);
      end
    end
    checks++;
    if (full !== 1'b1 || rdata !== 8'h11) begin
      errors++;
      $display("[TB] FAIL fill_full got full=%b rdata=%h want full=1 rdata=11", full, rdata);
    end
    cycle(1'b1, 8'h66, 1'b0, 1'b0);
    checks++;
    if (level !== 3'd5 || overflow !== ERR_EN || rdata !== 8'h11) begin
      errors++;
      $display("[TB] FAIL overflow got level=%0d ovf=%b rdata=%h want 5 %b 11", level, overflow, ERR_EN, rdata);
    end
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i * 8'h11);
      checks++;
      if (rdata !== d) begin
        errors++;
        $display("[TB] FAIL drain_data got %h want %h", rdata, d);
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (almost_empty !== ((5 - i) <= 1)) begin
        errors++;
        $display("[TB] FAIL drain_almost_empty got %b want %b at level %0d", almost_empty, ((5 - i) <= 1), 5 - i);
      end
    end
    checks++;
    if (empty !== 1'b1 || rdata !== 8'h00 || underflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_empty got empty=%b rdata=%h unf=%b want 1 00 0", empty, rdata, underflow);
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, 8'h21, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h23, 1'b0, 1'b0);
    checks++;
    if (level !== 3'd3 || overflow !== ERR_EN) begin
      errors++;
      $display("[TB] FAIL preflush got level=%0d ovf=%b want 3 %b", level, overflow, ERR_EN);
    end
    cycle(1'b1, 8'h99, 1'b1, 1'b1);
    checks++;
    if (level !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 || rdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL flush got level=%0d empty=%b ovf=%b unf=%b rdata=%h want 0 1 0 0 00",
               level, empty, overflow, underflow, rdata);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (level !== 3'd0 || empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_nostore got level=%0d empty=%b want 0 1", level, empty);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    for (int i = 1; i <= 12; i++) begin
      d = 8'(i);
      cycle(1'b1, d, 1'b0, 1'b0);
      checks++;
      if (level !== 3'd1 || rdata !== d) begin
        errors++;
        $display("[TB] FAIL wrap_push got level=%0d rdata=%h want 1 %h", level, rdata, d);
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (level !== 3'd0 || empty !== 1'b1) begin
        errors++;
        $display("[TB] FAIL wrap_pop got level=%0d empty=%b want 0 1", level, empty);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [5];
    exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB0};
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hB0, 1'b1, 1'b0);
    checks++;
    if (level !== 3'd5 || full !== 1'b1 || rdata !== 8'hA1 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pushpop_full got level=%0d full=%b rdata=%h ovf=%b want 5 1 a1 0",
               level, full, rdata, overflow);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rdata !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL pushpop_drain got %h want %h", rdata, exp_q[i]);
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    cycle(1'b1, 8'hA5, 1'b1, 1'b0);
    checks++;
    if (level !== 3'd1 || rdata !== 8'hA5 || underflow !== ERR_EN || empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pushpop_empty got level=%0d rdata=%h unf=%b empty=%b want 1 a5 %b 0",
               level, rdata, underflow, empty, ERR_EN);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 8'h31, 1'b0, 1'b0);
    cycle(1'b1, 8'h32, 1'b0, 1'b0);
    checks++;
    if (level !== 3'd3 || rdata !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL prereset got level=%0d rdata=%h want 3 a5", level, rdata);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (level !== 3'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || underflow !== 1'b0 || rdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL async_reset got level=%0d empty=%b ae=%b unf=%b rdata=%h want 0 1 1 0 00",
               level, empty, almost_empty, underflow, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (level !== 3'd0 || underflow !== ERR_EN) begin
      errors++;
      $display("[TB] FAIL post_reset_underrun got level=%0d unf=%b want 0 %b", level, underflow, ERR_EN);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
    wdata = 8'h00;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_fill_drain();
    test_flush();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
